// File: rtl/ad9361_tx_deframer.sv
// AD9361 6-bit transmit-port deframer: frame alignment, 12-bit I/Q
// reassembly, lock tracking and framing-error statistics.
module ad9361_tx_deframer #(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_cnt,
    input  logic                 tx_frame,
    input  logic [5:0]           tx_data,
    output logic                 dout_valid,
    output logic [11:0]          dout_i,
    output logic [11:0]          dout_q,
    output logic                 locked,
    output logic                 frame_err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    state_t     r_state;
    logic [1:0] r_phase;
    logic [3:0] r_good_cnt;
    logic       r_f;
    logic       r_fp;
    logic [5:0] r_d;
    logic [5:0] r_i_hi;
    logic [5:0] r_i_lo;
    logic [5:0] r_q_hi;

    logic       w_w0;
    logic       w_exp;
    logic       w_match;
    logic       w_active;
    logic       w_err_inc;
    logic       w_smp_inc;
    logic [3:0] w_good_nxt;

    // W0 starts on a rising frame edge; words 0/1 carry frame 1, 2/3 frame 0
    assign w_w0       = r_f & ~r_fp;
    assign w_exp      = ~r_phase[1];
    assign w_match    = (r_f == w_exp);
    assign w_active   = en && (r_state != S_HUNT);
    assign w_err_inc  = w_active && !w_match;
    assign w_smp_inc  = en && (r_state == S_LOCKED) && w_match && (r_phase == 2'd3);
    assign w_good_nxt = r_good_cnt + 4'd1;

    // Input stage: register pins once and keep the previous frame bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f  <= 1'b0;
            r_fp <= 1'b0;
            r_d  <= 6'd0;
        end else begin
            r_f  <= tx_frame;
            r_fp <= r_f;
            r_d  <= tx_data;
        end
    end

    // Alignment FSM with sample reassembly and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HUNT;
            r_phase    <= 2'd0;
            r_good_cnt <= 4'd0;
            r_i_hi     <= 6'd0;
            r_i_lo     <= 6'd0;
            r_q_hi     <= 6'd0;
            dout_valid <= 1'b0;
            dout_i     <= 12'd0;
            dout_q     <= 12'd0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!en) begin
                r_state    <= S_HUNT;
                r_phase    <= 2'd0;
                r_good_cnt <= 4'd0;
                locked     <= 1'b0;
            end else if (r_state == S_HUNT) begin
                locked <= 1'b0;
                if (w_w0) begin
                    r_i_hi  <= r_d;
                    r_phase <= 2'd1;
                    r_state <= S_SYNC;
                end
            end else if (w_match) begin
                r_phase <= r_phase + 2'd1;
                case (r_phase)
                    2'd0: r_i_hi <= r_d;
                    2'd1: r_i_lo <= r_d;
                    2'd2: r_q_hi <= r_d;
                    default: begin
                        if (r_state == S_SYNC) begin
                            r_good_cnt <= w_good_nxt;
                            if (w_good_nxt >= LC) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            dout_valid <= 1'b1;
                            dout_i     <= {r_i_hi, r_i_lo};
                            dout_q     <= {r_q_hi, r_d};
                        end
                    end
                endcase
            end else begin
                frame_err  <= 1'b1;
                r_good_cnt <= 4'd0;
                locked     <= 1'b0;
                if (w_w0) begin
                    r_i_hi  <= r_d;
                    r_phase <= 2'd1;
                    r_state <= S_SYNC;
                end else begin
                    r_phase <= 2'd0;
                    r_state <= S_HUNT;
                end
            end
        end
    end

    // Statistics: saturating error count, wrapping sample count, clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count    <= '0;
            sample_count <= '0;
        end else if (clr_cnt) begin
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            if (w_err_inc && (err_count != '1))
                err_count <= err_count + 1'b1;
            if (w_smp_inc)
                sample_count <= sample_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ad9361_tx_deframer.sv
// Directed bench for ad9361_tx_deframer: alignment, lock, errors,
// counter saturation/wrap/clear, async reset and enable gating.
module tb_ad9361_tx_deframer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr_cnt;
    logic          tx_frame;
    logic [5:0]    tx_data;
    logic          dout_valid;
    logic [11:0]   dout_i;
    logic [11:0]   dout_q;
    logic          locked;
    logic          frame_err;
    logic [CW-1:0] err_count;
    logic [CW-1:0] sample_count;

    int total = 0;
    int bad   = 0;
    int n_v   = 0;
    int n_e   = 0;
    int v0;
    int e0;
    logic prev_v = 1'b0;
    logic [11:0] last_i = 12'd0;
    logic [11:0] last_q = 12'd0;

    always #5 clk = ~clk;

    ad9361_tx_deframer #(.LOCK_COUNT(4), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr_cnt      (clr_cnt),
        .tx_frame     (tx_frame),
        .tx_data      (tx_data),
        .dout_valid   (dout_valid),
        .dout_i       (dout_i),
        .dout_q       (dout_q),
        .locked       (locked),
        .frame_err    (frame_err),
        .err_count    (err_count),
        .sample_count (sample_count)
    );

    // Strobe/error monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                total++;
                assert (prev_v === 1'b0) else begin
                    bad++;
                    $error("FAIL b2b_strobe: observed=1 expected=0");
                end
                n_v++;
                last_i = dout_i;
                last_q = dout_q;
            end
            if (frame_err) n_e++;
            prev_v = dout_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic [5:0] d);
        tx_frame = f;
        tx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] i, input logic [11:0] q,
                        input logic [3:0] fm);
        step(fm[3], i[11:6]);
        step(fm[2], i[5:0]);
        step(fm[1], q[11:6]);
        step(fm[0], q[5:0]);
    endtask

    task automatic send_ok(input logic [11:0] i, input logic [11:0] q);
        send(i, q, 4'b1100);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr_cnt = 1'b0;
        tx_frame = 1'b0; tx_data = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_i", 32'(dout_i), 32'd0);
        chk("rst_q", 32'(dout_q), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_smpcnt", 32'(sample_count), 32'd0);
        rst = 1'b0;

        // stream starts at W2/W3 of a sample, then aligned samples
        step(1'b0, 6'h3F);
        step(1'b0, 6'h01);
        repeat (4) send_ok(12'hA5C, 12'h3F1);
        chk("pre_lock", 32'(locked), 32'd0);
        chk("midstart_noerr", 32'(n_e), 32'd0);
        send_ok(12'hA5C, 12'h3F1);
        chk("lock_rise", 32'(locked), 32'd1);
        chk("no_strobe_sync", 32'(n_v), 32'd0);
        send_ok(12'hA5C, 12'h3F1);
        chk("first_strobe", 32'(n_v), 32'd1);
        chk("first_i", 32'(last_i), 32'hA5C);
        chk("first_q", 32'(last_q), 32'h3F1);
        chk("smpcnt1", 32'(sample_count), 32'd1);
        repeat (3) send_ok(12'hA5C, 12'h3F1);
        chk("strobes4", 32'(n_v), 32'd4);
        chk("smpcnt4", 32'(sample_count), 32'd4);
        send_ok(12'h123, 12'hFED);
        send_ok(12'hA5C, 12'h3F1);
        chk("var_i", 32'(last_i), 32'h123);
        chk("var_q", 32'(last_q), 32'hFED);
        chk("smpcnt6", 32'(sample_count), 32'd6);
        chk("noerr_run", 32'(n_e), 32'd0);

        // frame forced high during W2 while locked
        send(12'hA5C, 12'h3F1, 4'b1110);
        chk("w2_ferr", 32'(frame_err), 32'd1);
        v0 = n_v;
        step(1'b1, 6'h29);
        chk("w2_lockdrop", 32'(locked), 32'd0);
        chk("w2_ferr_pulse", 32'(frame_err), 32'd0);
        chk("w2_errcnt", 32'(err_count), 32'd1);
        step(1'b1, 6'h1C);
        step(1'b0, 6'h0F);
        step(1'b0, 6'h31);
        repeat (3) send_ok(12'hA5C, 12'h3F1);
        chk("w2_nolock", 32'(locked), 32'd0);
        send_ok(12'hA5C, 12'h3F1);
        chk("w2_relock", 32'(locked), 32'd1);
        chk("w2_nostrobe", 32'(n_v), 32'(v0));
        send_ok(12'hA5C, 12'h3F1);
        chk("w2_strobe", 32'(n_v), 32'(v0 + 1));
        chk("w2_errs", 32'(n_e), 32'd1);

        // frame slipped by one word while locked
        step(1'b1, 6'h29);
        step(1'b1, 6'h1C);
        step(1'b0, 6'h0F);
        v0 = n_v;
        repeat (4) send_ok(12'h123, 12'hFED);
        chk("slip_nolock", 32'(locked), 32'd0);
        chk("slip_errs", 32'(n_e), 32'd2);
        send_ok(12'h123, 12'hFED);
        chk("slip_relock", 32'(locked), 32'd1);
        chk("slip_nostrobe", 32'(n_v), 32'(v0));
        send_ok(12'h123, 12'hFED);
        chk("slip_strobe", 32'(n_v), 32'(v0 + 1));
        chk("slip_i", 32'(last_i), 32'h123);
        chk("slip_errs2", 32'(n_e), 32'd2);
        chk("slip_errcnt", 32'(err_count), 32'd2);

        // drive err_count into saturation
        repeat (300) begin
            step(1'b1, 6'd0);
            step(1'b0, 6'd0);
        end
        chk("sat_errcnt", 32'(err_count), 32'hFF);
        chk("sat_nerr", 32'(n_e > 255), 32'd1);
        repeat (10) begin
            step(1'b1, 6'd0);
            step(1'b0, 6'd0);
        end
        chk("sat_hold", 32'(err_count), 32'hFF);
        chk("sat_unlocked", 32'(locked), 32'd0);

        // relock, then clear coinciding with a strobe
        repeat (6) send_ok(12'hA5C, 12'h3F1);
        chk("clr_prelock", 32'(locked), 32'd1);
        clr_cnt = 1'b1;
        step(1'b1, 6'h29);
        chk("clr_strobe", 32'(dout_valid), 32'd1);
        step(1'b1, 6'h1C);
        clr_cnt = 1'b0;
        chk("clr_smpcnt", 32'(sample_count), 32'd0);
        chk("clr_errcnt", 32'(err_count), 32'd0);
        v0 = n_v;
        step(1'b0, 6'h0F);
        step(1'b0, 6'h31);

        // sample_count wraps through all-ones
        repeat (260) send_ok(12'hA5C, 12'h3F1);
        chk("wrap_strobes", 32'(n_v - v0), 32'd260);
        chk("wrap_smpcnt", 32'(sample_count), 32'd4);

        // async reset mid-sample while locked
        step(1'b1, 6'h29);
        step(1'b1, 6'h1C);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_i", 32'(dout_i), 32'd0);
        chk("arst_q", 32'(dout_q), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_errcnt", 32'(err_count), 32'd0);
        chk("arst_smpcnt", 32'(sample_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        v0 = n_v;
        e0 = n_e;
        step(1'b0, 6'h0F);
        step(1'b0, 6'h31);
        repeat (4) send_ok(12'hA5C, 12'h3F1);
        chk("arst_nostrobe", 32'(n_v), 32'(v0));
        chk("arst_nolock", 32'(locked), 32'd0);
        send_ok(12'hA5C, 12'h3F1);
        chk("arst_relock", 32'(locked), 32'd1);
        send_ok(12'hA5C, 12'h3F1);
        chk("arst_strobe", 32'(n_v), 32'(v0 + 1));
        chk("arst_noerr", 32'(n_e), 32'(e0));

        // en low for 10 words while the stream keeps running
        v0 = n_v;
        e0 = n_e;
        en = 1'b0;
        send_ok(12'h123, 12'hFED);
        send_ok(12'h123, 12'hFED);
        step(1'b1, 6'h04);
        step(1'b1, 6'h23);
        chk("en_unlocked", 32'(locked), 32'd0);
        chk("en_nostrobe", 32'(n_v), 32'(v0));
        chk("en_noerr", 32'(n_e), 32'(e0));
        chk("en_hold_i", 32'(dout_i), 32'hA5C);
        en = 1'b1;
        step(1'b0, 6'h3F);
        step(1'b0, 6'h2D);
        repeat (4) send_ok(12'h123, 12'hFED);
        chk("en_nolock", 32'(locked), 32'd0);
        send_ok(12'h123, 12'hFED);
        chk("en_relock", 32'(locked), 32'd1);
        send_ok(12'h123, 12'hFED);
        chk("en_strobe", 32'(n_v), 32'(v0 + 1));
        chk("en_q", 32'(last_q), 32'hFED);
        chk("en_errs", 32'(n_e), 32'(e0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
